// File: rtl/host_spi_pkg.sv
// Shared types and constants for the host SPI receiver.
package host_spi_pkg;
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} rx_state_e;
  localparam int ENTRY_W = 9;
  localparam int DC_BIT  = 8;
endpackage

// File: rtl/host_spi_rx_byte_fifo.sv
// First-word-fall-through FIFO with registered head entry and a drop pulse.
module byte_fifo
  import host_spi_pkg::*;
#(
  parameter int W     = ENTRY_W,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr, rd_next;
  logic         pop, full, empty, wr_en;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign pop     = out_valid & pop_ready & ~empty;
  assign wr_en   = push & (~full | pop);
  assign ovf     = push & full & ~pop;
  assign rd_next = rd_ptr + (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // The head register only sees entries committed before this edge, which
  // adds the one cycle between the memory write and OUT_VALID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      rd_ptr    <= rd_next;
      out_valid <= (rd_next != wr_ptr);
      if (rd_next != wr_ptr) out_data <= mem[rd_next[AW-1:0]];
    end
  end
endmodule

// File: rtl/host_spi_rx.sv
// SPI mode-0 slave receiver oversampled in CLK12; header byte selects D/C,
// payload bytes are queued for the OLED controller.
module host_spi_rx
  import host_spi_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK12,
  input  logic       RST,
  input  logic       SCK,
  input  logic       MOSI,
  input  logic       CSb,
  output logic [7:0] OUT_DATA,
  output logic       OUT_DC,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic       OVERFLOW,
  input  logic       OVF_CLR,
  output logic       BUSY
);
  logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, csb_sync;
  logic                   sck_d, csb_d;
  logic                   sck_s, mosi_s, csb_s;
  logic                   sck_rise, csb_fall, csb_rise;

  always_ff @(posedge CLK12 or posedge RST) begin
    if (RST) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      csb_sync  <= '1;
      sck_d     <= 1'b0;
      csb_d     <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      csb_sync  <= {csb_sync[SYNC_STAGES-2:0], CSb};
      sck_d     <= sck_s;
      csb_d     <= csb_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign csb_s    = csb_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign csb_fall = ~csb_s & csb_d;
  assign csb_rise = csb_s & ~csb_d;
  assign BUSY     = ~csb_s;

  rx_state_e          state;
  logic [2:0]         bit_cnt;
  logic [6:0]         shreg;      // the eighth bit is taken straight from mosi_s
  logic               dc;
  logic               push;
  logic [ENTRY_W-1:0] push_data;

  always_ff @(posedge CLK12 or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      dc        <= 1'b0;
      push      <= 1'b0;
      push_data <= '0;
    end else begin
      push <= 1'b0;
      if (csb_fall) begin
        bit_cnt <= '0;
        shreg   <= '0;
        state   <= HEADER;
      end else if (csb_rise) begin
        state <= IDLE;
      end else if (sck_rise && !csb_s && state != IDLE) begin
        shreg   <= {shreg[5:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          if (state == HEADER) begin
            dc    <= mosi_s;
            state <= PAYLOAD;
          end else begin
            push      <= 1'b1;
            push_data <= {dc, shreg, mosi_s};
          end
        end
      end
    end
  end

  logic [ENTRY_W-1:0] head;
  logic               ovf_pulse;

  byte_fifo #(.W(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (CLK12),
    .rst       (RST),
    .push      (push),
    .push_data (push_data),
    .pop_ready (OUT_READY),
    .out_valid (OUT_VALID),
    .out_data  (head),
    .ovf       (ovf_pulse)
  );

  assign OUT_DATA = head[7:0];
  assign OUT_DC   = head[DC_BIT];

  always_ff @(posedge CLK12 or posedge RST) begin
    if (RST)            OVERFLOW <= 1'b0;
    else if (ovf_pulse) OVERFLOW <= 1'b1;
    else if (OVF_CLR)   OVERFLOW <= 1'b0;
  end
endmodule
